// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (I) and load/store (D); D has priority, I is forced after STARVE_LIMIT D wins.
// Latency: a request seen in IDLE drives m_request on the next edge; completion is reported combinationally in the m_valid cycle.
// Backpressure: one transaction outstanding; requests are ignored while busy. Optional watchdog enabled by macro ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_request,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_request,
  input  logic        d_we_re,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_request,
  output logic        m_we_re,
  output logic [3:0]  m_mask,
  output logic [31:0] m_address,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_valid,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        grant_d, grant_i;
  logic        done, abort, finish;
  logic [31:0] resp;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Watchdog: counts BUSY cycles without a response; held at zero in IDLE so it starts clean on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!m_valid && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A response arriving on the timeout cycle takes precedence over the abort.
  assign abort = (state == BUSY) && tmo_hit && !m_valid;
`else
  assign abort = 1'b0;
`endif

  // Next state, arbitration, starvation bookkeeping and completion outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done       = (state == BUSY) && m_valid;
    finish     = done || abort;
    resp       = abort ? 32'hDEAD_BEEF : m_rdata;
    i_valid    = finish && !owner;
    d_valid    = finish && owner;
    i_rdata    = i_valid ? resp : 32'h0;
    d_rdata    = d_valid ? resp : 32'h0;
    timeout_err = abort;

    case (state)
      IDLE: begin
        if (d_request && !(i_request && starve_cnt == LIMIT)) begin
          grant_d = 1'b1;
        end else if (i_request) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          // Only D wins that leave I waiting count toward starvation.
          if (i_request) begin
            starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
          end else begin
            starve_nxt = 4'd0;
          end
          state_nxt = BUSY;
        end else if (grant_i) begin
          starve_nxt = 4'd0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

  // State, starvation counter and the registered memory-side request fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      m_request  <= 1'b0;
      m_we_re    <= 1'b0;
      m_mask     <= 4'd0;
      m_address  <= 32'h0;
      m_wdata    <= 32'h0;
      owner      <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_d) begin
        m_request <= 1'b1;
        m_we_re   <= d_we_re;
        m_mask    <= d_mask;
        m_address <= d_address;
        m_wdata   <= d_wdata;
        owner     <= 1'b1;
      end else if (grant_i) begin
        m_request <= 1'b1;
        m_we_re   <= 1'b0;
        m_mask    <= i_mask;
        m_address <= i_address;
        m_wdata   <= 32'h0;
        owner     <= 1'b0;
      end else if (finish) begin
        m_request <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run against a reference model.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Timeout scenario is exercised only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_request, d_request, d_we_re, m_valid;
  logic [3:0]  i_mask, d_mask;
  logic [31:0] i_address, d_address, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_address, m_wdata;
  logic        i_valid, d_valid, m_request, m_we_re, owner, busy, timeout_err;
  logic [3:0]  m_mask;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_mask(i_mask), .i_address(i_address),
    .i_rdata(i_rdata), .i_valid(i_valid),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .m_request(m_request), .m_we_re(m_we_re), .m_mask(m_mask),
    .m_address(m_address), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_valid(m_valid),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    i_request = 0; i_mask = 0; i_address = 0;
    d_request = 0; d_we_re = 0; d_mask = 0; d_address = 0; d_wdata = 0;
    m_valid = 0; m_rdata = 0;
  endtask

  // Both requesters held high, memory answers in the first BUSY cycle.
  // Expected winner pattern from the starvation rule: LIMIT D grants, then one I grant, repeating.
  task automatic run_contention(input int n, input string tag);
    i_request = 1; i_address = 32'h0000_0400; i_mask = 4'hF;
    d_request = 1; d_we_re = 0; d_address = 32'h0000_3000; d_mask = 4'hF;
    for (int g = 0; g < n; g++) begin
      logic exp_d;
      exp_d = ((g % (LIMIT + 1)) != LIMIT);
      tick;
      check({tag, "_owner"}, 32'(owner), 32'(exp_d));
      check({tag, "_mreq"}, 32'(m_request), 32'd1);
      check({tag, "_addr"}, m_address, exp_d ? 32'h0000_3000 : 32'h0000_0400);
      m_valid = 1; m_rdata = 32'(g) + 32'h100;
      settle;
      check({tag, "_dvalid"}, 32'(d_valid), 32'(exp_d));
      check({tag, "_ivalid"}, 32'(i_valid), 32'(!exp_d));
      tick;
      m_valid = 0;
      check({tag, "_gap"}, 32'(m_request), 32'd0);
    end
    i_request = 0; d_request = 0;
  endtask

  // Reference model state for the randomized phase.
  logic        mb, mo, mwe;
  logic [3:0]  mmask;
  logic [31:0] maddr, mwd;
  int          mstarve, waitc;

  initial begin
    idle_inputs();
    rst = 0;
    tick; tick;
    // Reset values
    check("rst_mreq",  32'(m_request), 0);
    check("rst_mwe",   32'(m_we_re), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_ivld",  32'(i_valid), 0);
    check("rst_dvld",  32'(d_valid), 0);
    check("rst_tmo",   32'(timeout_err), 0);
    check("rst_mask",  32'(m_mask), 0);
    check("rst_addr",  m_address, 0);
    check("rst_wdata", m_wdata, 0);
    rst = 1;
    tick;

    // I-only read
    i_request = 1; i_address = 32'h100; i_mask = 4'hF;
    settle;
    check("ird_pre_mreq", 32'(m_request), 0);
    tick;
    check("ird_mreq",  32'(m_request), 1);
    check("ird_mwe",   32'(m_we_re), 0);
    check("ird_addr",  m_address, 32'h100);
    check("ird_wdata", m_wdata, 0);
    check("ird_owner", 32'(owner), 0);
    i_request = 0;
    tick; tick;
    check("ird_wait_ivld", 32'(i_valid), 0);
    m_valid = 1; m_rdata = 32'h0050_0093;
    settle;
    check("ird_ivld",  32'(i_valid), 1);
    check("ird_rdata", i_rdata, 32'h0050_0093);
    check("ird_dvld",  32'(d_valid), 0);
    check("ird_drdata", d_rdata, 0);
    tick;
    m_valid = 0;
    check("ird_busy_fall", 32'(busy), 0);
    check("ird_mreq_fall", 32'(m_request), 0);

    // D store, fields must hold while inputs wander
    d_request = 1; d_we_re = 1; d_mask = 4'b0011; d_address = 32'h2004; d_wdata = 32'hA5A5;
    tick;
    d_request = 0; d_we_re = 0; d_mask = 4'hC; d_address = 32'hFFFF_0000; d_wdata = 32'h1;
    for (int k = 0; k < 3; k++) begin
      check("dst_mreq", 32'(m_request), 1);
      check("dst_mwe",  32'(m_we_re), 1);
      check("dst_mask", 32'(m_mask), 32'h3);
      check("dst_addr", m_address, 32'h2004);
      check("dst_wdat", m_wdata, 32'hA5A5);
      check("dst_owner", 32'(owner), 1);
      tick;
    end
    m_valid = 1; m_rdata = 32'h1234_5678;
    settle;
    check("dst_dvld",   32'(d_valid), 1);
    check("dst_drdata", d_rdata, 32'h1234_5678);
    check("dst_ivld",   32'(i_valid), 0);
    check("dst_irdata", i_rdata, 0);
    check("dst_busy_hold", 32'(busy), 1);
    tick;
    m_valid = 0;
    check("dst_busy_fall", 32'(busy), 0);
    idle_inputs();

    // Stray m_valid in IDLE
    m_valid = 1; m_rdata = 32'hCAFE_F00D;
    settle;
    check("stray_ivld", 32'(i_valid), 0);
    check("stray_dvld", 32'(d_valid), 0);
    check("stray_irdata", i_rdata, 0);
    tick;
    m_valid = 0;
    check("stray_busy", 32'(busy), 0);

    // Early drop of request after grant
    i_request = 1; i_address = 32'h200; i_mask = 4'hF;
    tick;
    i_request = 0;
    tick;
    check("drop_busy", 32'(busy), 1);
    m_valid = 1; m_rdata = 32'h7777_0001;
    settle;
    check("drop_ivld", 32'(i_valid), 1);
    check("drop_rdata", i_rdata, 32'h7777_0001);
    tick;
    m_valid = 0;

    // Contention / starvation from a clean counter
    rst = 0; tick; rst = 1;
    run_contention(12, "starve");

    // Reset mid-transaction; starvation history must also be forgotten
    d_request = 1; d_address = 32'h5000;
    tick;
    check("rmid_busy", 32'(busy), 1);
    d_request = 0;
    rst = 0;
    tick;
    check("rmid_mreq", 32'(m_request), 0);
    check("rmid_busyclr", 32'(busy), 0);
    check("rmid_addr", m_address, 0);
    rst = 1;
    m_valid = 1; m_rdata = 32'h3333_3333;
    settle;
    check("rmid_late_dvld", 32'(d_valid), 0);
    check("rmid_late_ivld", 32'(i_valid), 0);
    tick;
    m_valid = 0;
    check("rmid_idle", 32'(busy), 0);
    run_contention(5, "post_rst");

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: 16 silent BUSY cycles, then a one-cycle abort
    idle_inputs();
    d_request = 1; d_address = 32'h6000;
    tick;
    d_request = 0;
    for (int k = 0; k < 16; k++) begin
      settle;
      check("tmo_wait_err", 32'(timeout_err), 0);
      check("tmo_wait_dvld", 32'(d_valid), 0);
      tick;
    end
    settle;
    check("tmo_err",    32'(timeout_err), 1);
    check("tmo_dvld",   32'(d_valid), 1);
    check("tmo_drdata", d_rdata, 32'hDEAD_BEEF);
    check("tmo_ivld",   32'(i_valid), 0);
    tick;
    check("tmo_idle", 32'(busy), 0);
    check("tmo_mreq", 32'(m_request), 0);
    check("tmo_err_clr", 32'(timeout_err), 0);
`endif

    // Randomized run against the reference model
    idle_inputs();
    rst = 0; tick; rst = 1;
    mb = 0; mo = 0; mwe = 0; mmask = 0; maddr = 0; mwd = 0; mstarve = 0; waitc = 0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_mreq", 32'(m_request), 32'(mb));
      check("rnd_busy", 32'(busy), 32'(mb));
      if (mb) begin
        check("rnd_owner", 32'(owner), 32'(mo));
        check("rnd_addr",  m_address, maddr);
        check("rnd_mask",  32'(m_mask), 32'(mmask));
        check("rnd_mwe",   32'(m_we_re), 32'(mwe));
        check("rnd_wdata", m_wdata, mwd);
      end
      i_request = ($urandom_range(0, 3) != 0);
      d_request = ($urandom_range(0, 2) != 0);
      i_address = $urandom; i_mask = 4'($urandom);
      d_address = $urandom; d_mask = 4'($urandom); d_wdata = $urandom;
      d_we_re = 1'($urandom);
      m_rdata = $urandom;
      if (mb) m_valid = (waitc >= 8) || ($urandom_range(0, 2) == 0);
      else    m_valid = ($urandom_range(0, 5) == 0);
      settle;
      check("rnd_ivld", 32'(i_valid), 32'(mb && m_valid && !mo));
      check("rnd_dvld", 32'(d_valid), 32'(mb && m_valid && mo));
      check("rnd_irdata", i_rdata, (mb && m_valid && !mo) ? m_rdata : 32'h0);
      check("rnd_drdata", d_rdata, (mb && m_valid && mo) ? m_rdata : 32'h0);
      check("rnd_tmo", 32'(timeout_err), 0);
      if (mb) begin
        waitc++;
        if (m_valid) mb = 0;
      end else if (d_request && !(i_request && mstarve == LIMIT)) begin
        mb = 1; mo = 1; waitc = 0;
        mwe = d_we_re; mmask = d_mask; maddr = d_address; mwd = d_wdata;
        mstarve = i_request ? ((mstarve < LIMIT) ? mstarve + 1 : LIMIT) : 0;
      end else if (i_request) begin
        mb = 1; mo = 0; waitc = 0;
        mwe = 0; mmask = i_mask; maddr = i_address; mwd = 0;
        mstarve = 0;
      end
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester (I) and its load/store requester (D).
- Sits between the core's instruction_mem_*/data_mem_* signals and a single unified memory.
- D has fixed priority. A starvation counter forces an I grant after STARVE_LIMIT consecutive D grants while I is waiting.
- One transaction is outstanding at a time; it ends when the memory returns m_valid.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is pending before I is forced (legal range 1..15).
- TIMEOUT_CYCLES, 16: watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_request  in  1  instruction read request (level)
- i_mask  in  4  instruction byte mask
- i_address  in  32  instruction address
- i_rdata  out  32  instruction read data
- i_valid  out  1  instruction transaction done (1-cycle pulse)
- d_request  in  1  data request (level)
- d_we_re  in  1  1 = store, 0 = load
- d_mask  in  4  data byte mask
- d_address  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_valid  out  1  data transaction done (1-cycle pulse)
- m_request  out  1  memory request (registered)
- m_we_re  out  1  memory write enable (registered)
- m_mask  out  4  memory byte mask (registered)
- m_address  out  32  memory address (registered)
- m_wdata  out  32  memory write data (registered)
- m_rdata  in  32  memory read data
- m_valid  in  1  memory response valid
- owner  out  1  0 = I, 1 = D; meaningful only while busy
- busy  out  1  transaction outstanding
- timeout_err  out  1  watchdog abort pulse

Behaviour:
- Reset (rst == 0 at a clk edge): state IDLE, starve_cnt = 0.
  - m_request, m_we_re, busy, owner, i_valid, d_valid and timeout_err are 0.
  - m_mask, m_address and m_wdata are 0.
- States: IDLE and BUSY.
- IDLE arbitration, evaluated each cycle:
  - If only D requests, grant D.
  - If only I requests, grant I.
  - If both request, grant D unless starve_cnt == STARVE_LIMIT, in which case grant I.
- On a grant, the next edge does all of the following:
  - Latch the winner's fields into the m_* registers. For I, force m_we_re = 0 and m_wdata = 0.
  - Set m_request = 1, busy = 1, owner = winner, state = BUSY.
- Latency: a request seen in IDLE produces m_request one cycle later.
- starve_cnt update:
  - On a D grant while i_request is high, increment, saturating at STARVE_LIMIT.
  - On any I grant, clear to 0.
  - On a D grant with i_request low, clear to 0.
- BUSY:
  - m_* registers hold stable. Requester inputs are ignored.
  - A requester dropping its request after the grant does not cancel the transaction; the valid pulse is still issued.
- Completion (BUSY and m_valid == 1):
  - In that same cycle, combinationally: owner's *_valid = 1 and owner's *_rdata = m_rdata.
  - The non-owner's valid is 0. Both *_rdata outputs are 0 when not valid.
  - Next edge: m_request = 0, busy = 0, state = IDLE.
- Back-to-back: the earliest next m_request is 2 cycles after the m_valid cycle (1 IDLE cycle for arbitration).
- m_valid while in IDLE is ignored; no *_valid pulse is produced.
- Simultaneous first requests from I and D with starve_cnt < STARVE_LIMIT: D wins and I waits.
- Reset during BUSY: the transaction is abandoned. Outputs return to their reset values at that edge, and a late m_valid is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without m_valid.
  - If it reaches TIMEOUT_CYCLES, the transaction is aborted for one cycle, during which:
    - the owner's *_valid = 1 and *_rdata = 32'hDEAD_BEEF;
    - timeout_err = 1.
  - The next edge sets m_request = 0 and state = IDLE.
  - m_valid arriving in the same cycle as the timeout wins: normal completion, no error.
- When undefined:
  - No counter is built; BUSY waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- I-only read: i_request = 1, i_address = 0x100, m_valid 3 cycles after m_request with m_rdata = 0x00500093 -> m_request rises 1 cycle after i_request, m_we_re = 0, i_valid pulses with i_rdata = 0x00500093, d_valid stays 0.
- D store: d_request = 1, d_we_re = 1, d_mask = 4'b0011, d_address = 0x2004, d_wdata = 0xA5A5 -> m_* carry exactly these values and hold stable until m_valid; then d_valid pulses and busy falls next cycle.
- Contention and starvation with STARVE_LIMIT = 4: I and D held high continuously, memory answers in 1 cycle -> grant sequence is D, D, D, D, I, D, ...; starve_cnt is 0 after the I grant.
- Reset mid-transaction: rst = 0 while busy, then m_valid asserted afterwards -> m_request = 0 after that edge, no *_valid pulse, next grant behaves as from reset.
- Stray and early-drop cases:
  - m_valid pulse in IDLE -> no valid output.
  - Requester drops its request the cycle after grant -> transaction completes and valid is still pulsed.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16: memory never responds -> 16 BUSY cycles without m_valid, then timeout_err = 1 and d_valid = 1 with d_rdata = 0xDEAD_BEEF, then IDLE.
